shift_add_mult4: RTL
====================

Name: shift_add_mult4

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier.
- Sits directly around the 4-bit ripple adder: each cycle it supplies the adder's operands and registers the sum and carry-out the adder produces.
- Produces an 8-bit product after a fixed number of iterations.
- Uses a start/busy/done handshake toward the control logic.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal because the adder sub-module is fixed at 4 bits. Any other value fails at elaboration through a generate-time check.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply. Sampled only when busy=0.
- a  input  4  multiplicand, captured on an accepted start
- b  input  4  multiplier, captured on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product becomes valid
- product  output  8  registered result, a*b, unsigned

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high (clk, rst).
- On rst=1 at a clock edge:
  - state=IDLE, busy=0, done=0, product=8'h00
  - internal acc_hi, mq, mcand and cnt cleared
- Reset has priority over everything else, including mid-operation. An operation in flight is abandoned, product returns to 0 and no done pulse is produced.
- States:
  - IDLE: busy=0. start=1 moves to CALC and loads mcand<=a, mq<=b, acc_hi<=0, cnt<=0.
  - CALC: busy=1, done=0. Each cycle performs one step:
    - adder inputs are X = acc_hi and Y = mq[0] ? mcand : 4'b0000, with carryin=0
    - {acc_hi, mq} <= {carryout, S, mq[3:1]}
    - cnt <= cnt+1
    - after the step with cnt==3, go to DONE
  - DONE: busy=0. done=1 for exactly this cycle, and product takes {acc_hi, mq}. If start=1 in this cycle it is accepted and the block goes to CALC, so back-to-back operations incur no idle cycle. Otherwise it goes to IDLE.
- Latency:
  - start sampled at edge N
  - CALC occupies edges N+1 to N+4
  - done=1 and product valid in the cycle after edge N+4, i.e. 5 cycles after the start edge
- start while busy=1 is ignored; it is neither queued nor does it corrupt the operation.
- product holds its last value until the next completion or reset. It does not change when a new start is accepted.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out forms the MSB of the shifted-in acc_hi, so no overflow is possible; the maximum product is 15*15 = 225.
  - cnt is 2 bits and wraps to 0 on entry to CALC.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: if an accepted start has a==0 or b==0, the block skips CALC and goes straight to DONE on the next edge. done pulses 1 cycle after the start edge with product=0, and busy never asserts.
- Not defined: every operation takes the full 4-iteration path, including zero operands, and latency is always 5.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
  - ITERATIONS=4
  - PROD_W=8
- Sub-module: the existing 4-bit ripple adder bit4adder, instantiated once with ports in the order carryin, X, Y, S, carryout and carryin tied to 0.
- The FSM and datapath registers stay in shift_add_mult4.

Test Plan:
- Reset, then a=4'hF, b=4'hF, start pulse -> busy=1 for 4 cycles; done=1 five cycles after the start edge; product=8'hE1 (225).
- a=4'hA, b=4'h5 -> product=8'h32 (50). Then a=4'h5, b=4'hA with start held high through the DONE cycle -> second operation accepted without an idle cycle, product=8'h32, done pulses twice, 5 cycles apart.
- a=4'h3, b=4'h7 started; at cycle 2 of CALC apply start with a=4'hF, b=4'hF -> second start ignored; product=8'h15 (21).
- a=4'h9, b=4'h6 started; assert rst during cycle 3 of CALC -> the next cycle shows busy=0, done=0, product=0; no done pulse follows.
- a=4'h0, b=4'hB -> without MULT_ZERO_BYPASS_EN: done after 5 cycles, product=0. With MULT_ZERO_BYPASS_EN: done after 1 cycle, busy stays 0, product=0.
- a=4'h1, b=4'h8 and a=4'h8, b=4'h1 -> product=8'h08 in both cases. This checks mq[0] gating at both ends of the shift sequence.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// iteration count and datapath widths.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned ITERATIONS = 4;
    localparam int unsigned PROD_W     = 8;
    localparam int unsigned ADD_W      = 4;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // True on the iteration whose result completes the product.
    function automatic logic is_last_step(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(ITERATIONS - 1);
    endfunction

endpackage

// File: rtl/bit4adder.sv
// 4-bit ripple-carry adder.
// Ports:
//   carryin  - carry into bit 0
//   X, Y     - 4-bit addends
//   S        - 4-bit sum
//   carryout - carry out of bit 3
module bit4adder (
    input  logic       carryin,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] S,
    output logic       carryout
);

    logic [4:0] carry;

    assign carry[0] = carryin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]       = X[i] ^ Y[i] ^ carry[i];
        assign carry[i+1] = (X[i] & Y[i]) | (carry[i] & (X[i] ^ Y[i]));
    end

    assign carryout = carry[4];

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done
// handshake. One adder step per cycle; product valid 5 cycles after start.
// Optional macro MULT_ZERO_BYPASS_EN: a start with a zero operand skips the
// iterations and completes (product 0) one cycle after the start edge.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   start   - multiply request, sampled when not busy
//   a, b    - multiplicand / multiplier, captured on accepted start
//   busy    - high while iterating
//   done    - one-cycle pulse when product updates
//   product - registered unsigned a*b
module shift_add_mult4
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    // The adder is hard 4 bits wide, so no other operand width can work.
    if (WIDTH != ADD_W) begin : g_width_chk
        $error("shift_add_mult4: WIDTH must be 4");
    end

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [PROD_W-1:0]   product_q;
    logic [ADD_W-1:0]    acc_hi_q;
    logic [ADD_W-1:0]    mq_q;
    logic [ADD_W-1:0]    mcand_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [ADD_W-1:0]    add_y;
    logic [ADD_W-1:0]    add_s;
    logic                add_co;
    logic [ADD_W-1:0]    acc_hi_d;
    logic [ADD_W-1:0]    mq_d;
    logic                bypass_c;

    // Partial product for this step is gated by the current multiplier LSB.
    assign add_y = mq_q[0] ? mcand_q : '0;

    bit4adder u_adder (
        .carryin  (1'b0),
        .X        (acc_hi_q),
        .Y        (add_y),
        .S        (add_s),
        .carryout (add_co)
    );

    // Shift the 9-bit {carry, sum, mq} right by one into {acc_hi, mq}.
    assign acc_hi_d = {add_co, add_s[ADD_W-1:1]};
    assign mq_d     = {add_s[0], mq_q[ADD_W-1:1]};

`ifdef MULT_ZERO_BYPASS_EN
    assign bypass_c = (a == '0) || (b == '0);
`else
    assign bypass_c = 1'b0;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            acc_hi_q  <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    acc_hi_q <= acc_hi_d;
                    mq_q     <= mq_d;
                    cnt_q    <= CNT_W'(cnt_q + 1'b1);
                    if (is_last_step(cnt_q)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= {acc_hi_d, mq_d};
                    end
                end
                // IDLE and DONE both accept a new start.
                default: begin
                    if (start) begin
                        if (bypass_c) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else begin
                            state_q  <= CALC;
                            busy_q   <= 1'b1;
                            mcand_q  <= ADD_W'(a);
                            mq_q     <= ADD_W'(b);
                            acc_hi_q <= '0;
                            cnt_q    <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
